// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// FETCH_TIMEOUT_EN (optional) enables the request timeout; TIMEOUT_LIMIT applies only then.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        KILL = 2'd2
    } fetch_state_t;

    localparam logic [15:0] RESET_PC      = 16'h0000;
    localparam logic [3:0]  TIMEOUT_LIMIT = 4'd15;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Down-counter that flags a memory request outstanding for TIMEOUT_LIMIT cycles.
// Present only when FETCH_TIMEOUT_EN is defined.
`ifdef FETCH_TIMEOUT_EN
module fetch_timeout_ctr
    import fetch_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_run,
    output logic o_expired
);

    logic [3:0] r_cnt;

    // The counter reloads whenever the wait is broken, so only consecutive waiting cycles count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= TIMEOUT_LIMIT;
        end else if (!i_run || o_expired) begin
            r_cnt <= TIMEOUT_LIMIT;
        end else begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    assign o_expired = i_run && (r_cnt == 4'd1);

endmodule
`endif

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: single outstanding memory read, with redirect and squash handling.
// FETCH_TIMEOUT_EN adds a request timeout with a sticky error flag.
//
// state | meaning
// IDLE  | no request outstanding; accepts redirects and fetch requests
// REQ   | read outstanding; data will be delivered to the instruction register
// KILL  | read outstanding but squashed by a redirect; data will be discarded
module instr_fetch_unit
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        C_FetchEn,
    input  logic        C_Redirect,
    input  logic [15:0] D_RedirectAddr,
    output logic        M_ReqValid,
    output logic [15:0] M_Addr,
    input  logic        M_Ack,
    input  logic [15:0] M_RData,
    output logic [15:0] D_MemData,
    output logic        C_IRWrite,
    output logic [15:0] A_FetchPC,
    output logic [15:0] A_PC,
    output logic        C_Busy,
    output logic        C_FetchErr
);

    fetch_state_t r_state, w_state_nxt;
    logic [15:0]  r_pc, r_addr, r_mem_data, r_fetch_pc, r_pending;
    logic         r_irwrite;
    logic         w_busy, w_expired;
    logic         w_pc_we, w_addr_we, w_pend_we, w_ir_we;
    logic [15:0]  w_pc_d;

    assign w_busy = (r_state != IDLE);

`ifdef FETCH_TIMEOUT_EN
    logic r_err;

    fetch_timeout_ctr u_timeout (
        .clk       (clk),
        .rst       (rst),
        .i_run     (w_busy && !M_Ack),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_expired) begin
            r_err <= 1'b1;
        end
    end

    assign C_FetchErr = r_err;
`else
    assign w_expired  = 1'b0;
    assign C_FetchErr = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_pc_we     = 1'b0;
        w_pc_d      = r_pc;
        w_addr_we   = 1'b0;
        w_pend_we   = 1'b0;
        w_ir_we     = 1'b0;
        case (r_state)
            IDLE: begin
                if (C_Redirect) begin
                    w_pc_we = 1'b1;
                    w_pc_d  = D_RedirectAddr;
                end else if (C_FetchEn) begin
                    w_state_nxt = REQ;
                    w_addr_we   = 1'b1;
                end
            end
            REQ: begin
                if (M_Ack) begin
                    w_state_nxt = IDLE;
                    w_pc_we     = 1'b1;
                    if (C_Redirect) begin
                        w_pc_d = D_RedirectAddr;
                    end else begin
                        w_pc_d  = r_addr + 16'd1;
                        w_ir_we = 1'b1;
                    end
                end else if (w_expired) begin
                    w_state_nxt = IDLE;
                    w_pc_we     = C_Redirect;
                    w_pc_d      = D_RedirectAddr;
                end else if (C_Redirect) begin
                    w_state_nxt = KILL;
                    w_pend_we   = 1'b1;
                end
            end
            KILL: begin
                if (M_Ack || w_expired) begin
                    w_state_nxt = IDLE;
                    w_pc_we     = 1'b1;
                    w_pc_d      = C_Redirect ? D_RedirectAddr : r_pending;
                end else if (C_Redirect) begin
                    w_pend_we = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC;
            r_addr     <= 16'h0000;
            r_pending  <= 16'h0000;
            r_mem_data <= 16'h0000;
            r_fetch_pc <= 16'h0000;
            r_irwrite  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_irwrite <= w_ir_we;
            if (w_pc_we)   r_pc      <= w_pc_d;
            if (w_addr_we) r_addr    <= r_pc;
            if (w_pend_we) r_pending <= D_RedirectAddr;
            if (w_ir_we) begin
                r_mem_data <= M_RData;
                r_fetch_pc <= r_addr;
            end
        end
    end

    assign M_ReqValid = w_busy;
    assign C_Busy     = w_busy;
    assign M_Addr     = r_addr;
    assign D_MemData  = r_mem_data;
    assign A_FetchPC  = r_fetch_pc;
    assign A_PC       = r_pc;
    assign C_IRWrite  = r_irwrite;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit; timeout steps adapt to FETCH_TIMEOUT_EN.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        C_FetchEn, C_Redirect, M_Ack;
    logic [15:0] D_RedirectAddr, M_RData;
    logic        M_ReqValid, C_IRWrite, C_Busy, C_FetchErr;
    logic [15:0] M_Addr, D_MemData, A_FetchPC, A_PC;

    int n_assert = 0;
    int n_fail   = 0;

    instr_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .C_FetchEn      (C_FetchEn),
        .C_Redirect     (C_Redirect),
        .D_RedirectAddr (D_RedirectAddr),
        .M_ReqValid     (M_ReqValid),
        .M_Addr         (M_Addr),
        .M_Ack          (M_Ack),
        .M_RData        (M_RData),
        .D_MemData      (D_MemData),
        .C_IRWrite      (C_IRWrite),
        .A_FetchPC      (A_FetchPC),
        .A_PC           (A_PC),
        .C_Busy         (C_Busy),
        .C_FetchErr     (C_FetchErr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rv"},   32'(M_ReqValid), 32'h0);
        chk({tag, "_addr"}, 32'(M_Addr),     32'h0);
        chk({tag, "_pc"},   32'(A_PC),       32'h0);
        chk({tag, "_data"}, 32'(D_MemData),  32'h0);
        chk({tag, "_fpc"},  32'(A_FetchPC),  32'h0);
        chk({tag, "_irw"},  32'(C_IRWrite),  32'h0);
        chk({tag, "_busy"}, 32'(C_Busy),     32'h0);
        chk({tag, "_err"},  32'(C_FetchErr), 32'h0);
    endtask

    initial begin
        rst = 1'b1; C_FetchEn = 1'b0; C_Redirect = 1'b0; M_Ack = 1'b0;
        D_RedirectAddr = 16'h0; M_RData = 16'h0;
        step(); step();
        chk_reset_vals("reset");

        // release reset with a stray ack in the first cycle
        rst = 1'b0; M_Ack = 1'b1; M_RData = 16'hFACE;
        step();
        M_Ack = 1'b0;
        chk("post_rst_irw", 32'(C_IRWrite), 32'h0);
        chk("post_rst_pc",  32'(A_PC),      32'h0);

        // best-case fetch
        C_FetchEn = 1'b1;
        step();
        C_FetchEn = 1'b0;
        chk("f1_rv",   32'(M_ReqValid), 32'h1);
        chk("f1_addr", 32'(M_Addr),     32'h0);
        M_Ack = 1'b1; M_RData = 16'hA123;
        step();
        M_Ack = 1'b0;
        chk("f1_irw",  32'(C_IRWrite), 32'h1);
        chk("f1_data", 32'(D_MemData), 32'hA123);
        chk("f1_fpc",  32'(A_FetchPC), 32'h0);
        chk("f1_pc",   32'(A_PC),      32'h1);
        step();
        chk("f1_irw_off", 32'(C_IRWrite), 32'h0);
        chk("f1_hold",    32'(D_MemData), 32'hA123);
        chk("f1_busy",    32'(C_Busy),    32'h0);

        // ack delayed: 5 waiting cycles, fetch enable ignored while busy
        C_FetchEn = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("d_rv",   32'(M_ReqValid), 32'h1);
            chk("d_addr", 32'(M_Addr),     32'h1);
            chk("d_irw",  32'(C_IRWrite),  32'h0);
            step();
        end
        C_FetchEn = 1'b0; M_Ack = 1'b1; M_RData = 16'hBEEF;
        step();
        M_Ack = 1'b0;
        chk("d_irw1", 32'(C_IRWrite), 32'h1);
        chk("d_data", 32'(D_MemData), 32'hBEEF);
        chk("d_fpc",  32'(A_FetchPC), 32'h1);
        chk("d_pc",   32'(A_PC),      32'h2);
        step();
        chk("d_irw0", 32'(C_IRWrite), 32'h0);
        chk("d_busy", 32'(C_Busy),    32'h0);

        // redirect and ack in the same REQ cycle
        C_FetchEn = 1'b1;
        step();
        C_FetchEn = 1'b0;
        chk("ra_addr", 32'(M_Addr), 32'h2);
        C_Redirect = 1'b1; D_RedirectAddr = 16'h0010; M_Ack = 1'b1; M_RData = 16'hDEAD;
        step();
        C_Redirect = 1'b0; M_Ack = 1'b0;
        chk("ra_irw",  32'(C_IRWrite), 32'h0);
        chk("ra_pc",   32'(A_PC),      32'h0010);
        chk("ra_data", 32'(D_MemData), 32'hBEEF);
        chk("ra_busy", 32'(C_Busy),    32'h0);

        // redirect during REQ, ack three cycles later
        C_FetchEn = 1'b1;
        step();
        C_FetchEn = 1'b0;
        chk("k_addr0", 32'(M_Addr), 32'h0010);
        C_Redirect = 1'b1; D_RedirectAddr = 16'h0040;
        step();
        C_Redirect = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("k_rv",   32'(M_ReqValid), 32'h1);
            chk("k_addr", 32'(M_Addr),     32'h0010);
            step();
        end
        M_Ack = 1'b1; M_RData = 16'h1111;
        step();
        M_Ack = 1'b0;
        chk("k_irw",  32'(C_IRWrite), 32'h0);
        chk("k_pc",   32'(A_PC),      32'h0040);
        chk("k_data", 32'(D_MemData), 32'hBEEF);
        C_FetchEn = 1'b1;
        step();
        C_FetchEn = 1'b0;
        chk("k_next_addr", 32'(M_Addr), 32'h0040);
        M_Ack = 1'b1; M_RData = 16'h2222;
        step();
        M_Ack = 1'b0;
        chk("k_next_fpc", 32'(A_FetchPC), 32'h0040);
        chk("k_next_pc",  32'(A_PC),      32'h0041);

        // second redirect in KILL overwrites the pending address
        C_FetchEn = 1'b1;
        step();
        C_FetchEn = 1'b0;
        C_Redirect = 1'b1; D_RedirectAddr = 16'h0100;
        step();
        D_RedirectAddr = 16'h0200;
        step();
        C_Redirect = 1'b0; M_Ack = 1'b1;
        step();
        M_Ack = 1'b0;
        chk("ow_pc",  32'(A_PC),      32'h0200);
        chk("ow_irw", 32'(C_IRWrite), 32'h0);

        // redirect beats fetch enable in IDLE, then wrap at FFFF
        C_Redirect = 1'b1; D_RedirectAddr = 16'hFFFF; C_FetchEn = 1'b1;
        step();
        C_Redirect = 1'b0;
        chk("rw_busy", 32'(C_Busy), 32'h0);
        chk("rw_pc",   32'(A_PC),   32'hFFFF);
        step();
        C_FetchEn = 1'b0;
        chk("w_addr", 32'(M_Addr), 32'hFFFF);
        M_Ack = 1'b1; M_RData = 16'h5A5A;
        step();
        M_Ack = 1'b0;
        chk("w_fpc",  32'(A_FetchPC), 32'hFFFF);
        chk("w_pc",   32'(A_PC),      32'h0000);
        chk("w_data", 32'(D_MemData), 32'h5A5A);

        // no ack for 20 cycles
        C_FetchEn = 1'b1;
        step();
        C_FetchEn = 1'b0;
        for (int c = 1; c <= 20; c++) begin
`ifdef FETCH_TIMEOUT_EN
            chk("to_rv", 32'(M_ReqValid), (c <= 15) ? 32'h1 : 32'h0);
`else
            chk("to_rv", 32'(M_ReqValid), 32'h1);
`endif
            step();
        end
`ifdef FETCH_TIMEOUT_EN
        chk("to_err", 32'(C_FetchErr), 32'h1);
        chk("to_pc",  32'(A_PC),       32'h0);
`else
        chk("to_err", 32'(C_FetchErr), 32'h0);
`endif
        M_Ack = 1'b1; M_RData = 16'h7777;
        step();
        M_Ack = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        chk("to_late_irw", 32'(C_IRWrite),  32'h0);
        chk("to_err_hold", 32'(C_FetchErr), 32'h1);
`else
        chk("to_late_irw", 32'(C_IRWrite), 32'h1);
        chk("to_late_pc",  32'(A_PC),      32'h1);
`endif

        // reset asserted mid-request
        C_FetchEn = 1'b1;
        step();
        C_FetchEn = 1'b0;
        C_Redirect = 1'b1; D_RedirectAddr = 16'h0333;
        step();
        C_Redirect = 1'b0;
        chk("mr_rv", 32'(M_ReqValid), 32'h1);
        rst = 1'b1;
        #2;
        chk_reset_vals("midrst");
        step();
        rst = 1'b0; M_Ack = 1'b1;
        step();
        M_Ack = 1'b0;
        chk("mr_irw",  32'(C_IRWrite), 32'h0);
        chk("mr_busy", 32'(C_Busy),    32'h0);
        chk("mr_pc",   32'(A_PC),      32'h0);
        C_FetchEn = 1'b1;
        step();
        C_FetchEn = 1'b0;
        M_Ack = 1'b1; M_RData = 16'h9999;
        step();
        M_Ack = 1'b0;
        chk("mr_fetch_irw", 32'(C_IRWrite), 32'h1);
        chk("mr_fetch_pc",  32'(A_PC),      32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 C_FetchEn  input  1  control FSM requests the next instruction.
REQ-004 C_Redirect  input  1  one-cycle pulse: change fetch address (branch/jump).
REQ-005 D_RedirectAddr  input  16  new PC, sampled when C_Redirect=1.
REQ-006 M_ReqValid  output  1  memory read request.
REQ-007 M_Addr  output  16  word address of the request.
REQ-008 M_Ack  input  1  memory returns data this cycle.
REQ-009 M_RData  input  16  instruction word, valid when M_Ack=1.
REQ-010 D_MemData  output  16  fetched instruction word, to the instruction register.
REQ-011 C_IRWrite  output  1  one-cycle pulse: D_MemData is valid and shall be latched.
REQ-012 A_FetchPC  output  16  address of the word in D_MemData.
REQ-013 A_PC  output  16  next address to fetch.
REQ-014 C_Busy  output  1  high whenever the state is not IDLE.
REQ-015 C_FetchErr  output  1  sticky fetch-timeout flag; tied 0 without FETCH_TIMEOUT_EN.

Function
REQ-016 The FSM shall have three states: IDLE, REQ and KILL.
REQ-017 IDLE transitions:
- C_Redirect=1: A_PC<=D_RedirectAddr; stay IDLE (redirect wins over C_FetchEn).
- else C_FetchEn=1: go to REQ with M_Addr<=A_PC.
REQ-018 In REQ, M_ReqValid shall be 1 and M_Addr shall be held stable until the cycle with M_Ack=1.
REQ-019 REQ with M_Ack=1 and C_Redirect=0: next edge D_MemData<=M_RData, A_FetchPC<=M_Addr, A_PC<=M_Addr+1, C_IRWrite=1 for exactly one cycle, go to IDLE.
REQ-020 A_PC increment shall wrap 16'hFFFF -> 16'h0000.
REQ-021 REQ with M_Ack=1 and C_Redirect=1 in the same cycle:
- discard the data; no C_IRWrite.
- A_PC<=D_RedirectAddr; go to IDLE.
REQ-022 REQ with C_Redirect=1 and M_Ack=0:
- latch D_RedirectAddr as pending; go to KILL.
- M_ReqValid stays 1 and M_Addr stays unchanged.
REQ-023 KILL: a further C_Redirect shall overwrite the pending address.
REQ-024 KILL exit on M_Ack=1: discard the data, no C_IRWrite, A_PC<=pending address (or the same-cycle D_RedirectAddr if C_Redirect=1), go to IDLE.
REQ-025 Best-case latency: C_FetchEn in IDLE, then M_Ack in the first REQ cycle, gives C_IRWrite 2 cycles after C_FetchEn.
REQ-026 D_MemData and A_FetchPC shall hold their value between C_IRWrite pulses.
REQ-027 C_FetchEn shall be ignored outside IDLE.

Reset
REQ-028 Assertion of rst, at any time including mid-request, shall force:
- state=IDLE; A_PC=RESET_PC (16'h0000).
- D_MemData=0, A_FetchPC=0, C_IRWrite=0, M_ReqValid=0, M_Addr=0.
- C_FetchErr=0; pending redirect and timeout count cleared.
REQ-029 An M_Ack arriving in the first cycle after reset release shall be ignored.

Configuration
REQ-030 With FETCH_TIMEOUT_EN defined, a 4-bit counter shall count consecutive REQ/KILL cycles without M_Ack.
REQ-031 When that count reaches TIMEOUT_LIMIT (15):
- M_ReqValid shall drop and the state shall return to IDLE.
- C_FetchErr shall be set and held until reset.
- A_PC shall be unchanged from REQ, or take the pending address from KILL.
REQ-032 Without FETCH_TIMEOUT_EN, the counter shall be absent, REQ/KILL shall wait indefinitely, and C_FetchErr shall be 0.

Structure
REQ-033 Package fetch_pkg shall hold the state enum (IDLE, REQ, KILL), RESET_PC and TIMEOUT_LIMIT.
REQ-034 The timeout counter shall be sub-module fetch_timeout_ctr, instantiated only under FETCH_TIMEOUT_EN.

Verification
REQ-035 Reset then C_FetchEn=1, M_Ack in the first REQ cycle with M_RData=16'hA123 -> one C_IRWrite pulse, D_MemData=16'hA123, A_FetchPC=0, A_PC=1.
REQ-036 A_PC=16'hFFFF, fetch acked -> A_FetchPC=16'hFFFF, A_PC=16'h0000.
REQ-037 M_Ack delayed 5 cycles -> M_ReqValid and M_Addr stable for all 5 cycles; single C_IRWrite.
REQ-038 C_Redirect to 16'h0040 during REQ, M_Ack 3 cycles later -> no C_IRWrite, A_PC=16'h0040, next fetch M_Addr=16'h0040.
REQ-039 C_Redirect to 16'h0010 and M_Ack in the same REQ cycle -> data dropped, A_PC=16'h0010.
REQ-040 FETCH_TIMEOUT_EN defined, M_Ack never asserted -> M_ReqValid drops after 15 cycles, C_FetchErr=1 until rst; rst pulsed mid-request -> all outputs at reset values.
